// File: rtl/dsc_mul_n.sv
// Deterministic stochastic-computing multiplier: N counter-comparator stream
// generators enumerate every counter tuple once; the AND of all streams is counted.
module dsc_mul_n #(
    parameter int unsigned SNG_WIDTH  = 10,
    parameter int unsigned NUM_INPUTS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0]  din,
    output logic                             busy,
    output logic                             done,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0]  z,
    output logic                             sn_out
);

    localparam int unsigned W  = SNG_WIDTH;
    localparam int unsigned N  = NUM_INPUTS;
    localparam int unsigned TW = N * W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   x_q, x_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   acc_q, acc_d;
    logic [TW-1:0]   z_q, z_d;
    logic            done_q, done_d;

    logic [N-1:0]    gen_bit_c;
    logic [N-1:0]    inc_c;
    logic [TW-1:0]   cnt_inc_c;
    logic [TW-1:0]   acc_sum_c;
    logic            last_c;
    logic            any_zero_c;
    logic            sn_c;

    // Stream generators and enable-chained counters: c_i steps when c_0..c_{i-1} all wrap.
    always_comb begin
        logic carry;
        carry      = 1'b1;
        any_zero_c = 1'b0;
        gen_bit_c  = '0;
        inc_c      = '0;
        cnt_inc_c  = cnt_q;
        for (int unsigned i = 0; i < N; i++) begin
            gen_bit_c[i] = cnt_q[i*W +: W] < x_q[i*W +: W];
            inc_c[i]     = carry;
            cnt_inc_c[i*W +: W] = cnt_q[i*W +: W] + W'(carry);
            carry        = carry & (&cnt_q[i*W +: W]);
            if (din[i*W +: W] == '0) begin
                any_zero_c = 1'b1;
            end
        end
        last_c = carry;
    end

    assign sn_c      = (state_q == S_RUN) && (&gen_bit_c);
    assign acc_sum_c = acc_q + TW'(sn_c);

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        z_d     = z_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d = din;
                    if (any_zero_c) begin
                        z_d    = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_inc_c;
                acc_d = acc_sum_c;
                if (last_c) begin
                    z_d     = acc_sum_c;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            z_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = done_q;
    assign z      = z_q;
    assign sn_out = sn_c;

endmodule

// File: tb/tb_dsc_mul_n.sv
// Bench for dsc_mul_n: a 2x3-bit and a 4x2-bit instance checked against an
// enumeration model of the counter tuples and the plain arithmetic product.
module tb_dsc_mul_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       start2, busy2, done2, sn2;
    logic [5:0] din2, z2;
    logic       start4, busy4, done4, sn4;
    logic [7:0] din4, z4;

    int    checks = 0;
    int    errors = 0;
    longint exp_z2 = 0;
    longint exp_z4 = 0;

    always #5 clk = ~clk;

    dsc_mul_n #(.SNG_WIDTH(3), .NUM_INPUTS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .din(din2),
        .busy(busy2), .done(done2), .z(z2), .sn_out(sn2)
    );

    dsc_mul_n #(.SNG_WIDTH(2), .NUM_INPUTS(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .din(din4),
        .busy(busy4), .done(done4), .z(z4), .sn_out(sn4)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation on the 2-input instance; returns in the done cycle.
    // poke: RUN cycle at which a stray start with new din is issued (-1 none).
    // abort_at: RUN cycle at which reset is applied (-1 none).
    task automatic run2(input int x0, input int x1, input int poke,
                        input int abort_at, input string tag);
        int     cyc;
        int     ones;
        longint prod;
        logic   exp_sn;
        prod = longint'(x0 * x1);
        din2 = {3'(x1), 3'(x0)};
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        din2 = 6'($urandom);
        cyc = 0;
        ones = 0;
        while (busy2 === 1'b1 && cyc < 100) begin
            exp_sn = ((cyc % 8) < x0) && ((cyc / 8) < x1);
            chk({tag, " sn"}, longint'(sn2), longint'(exp_sn));
            chk({tag, " done_in_run"}, longint'(done2), 0);
            chk({tag, " z_held"}, longint'(z2), exp_z2);
            ones += int'(sn2);
            if (cyc == abort_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                exp_z2 = 0;
                chk({tag, " abort_busy"}, longint'(busy2), 0);
                chk({tag, " abort_done"}, longint'(done2), 0);
                chk({tag, " abort_z"}, longint'(z2), 0);
                return;
            end
            if (cyc == poke) begin
                din2 = '1;
                start2 = 1'b1;
            end
            step();
            start2 = 1'b0;
            if (cyc == poke) din2 = 6'($urandom);
            cyc++;
        end
        exp_z2 = prod;
        chk({tag, " run_cycles"}, longint'(cyc), (prod == 0) ? 0 : 64);
        chk({tag, " done"}, longint'(done2), 1);
        chk({tag, " busy_end"}, longint'(busy2), 0);
        chk({tag, " z"}, longint'(z2), prod);
        chk({tag, " sn_idle"}, longint'(sn2), 0);
        if (prod != 0) chk({tag, " ones"}, longint'(ones), prod);
    endtask

    task automatic idle2(input string tag);
        step();
        chk({tag, " done_pulse"}, longint'(done2), 0);
        chk({tag, " busy_idle"}, longint'(busy2), 0);
        chk({tag, " z_kept"}, longint'(z2), exp_z2);
    endtask

    // One operation on the 4-input instance; returns in the done cycle.
    task automatic run4(input int a, input int b, input int c, input int d,
                        input string tag);
        int     x[4];
        int     cyc;
        int     ones;
        longint prod;
        logic   exp_sn;
        x[0] = a; x[1] = b; x[2] = c; x[3] = d;
        prod = longint'(a * b * c * d);
        din4 = {2'(d), 2'(c), 2'(b), 2'(a)};
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        din4 = 8'($urandom);
        cyc = 0;
        ones = 0;
        while (busy4 === 1'b1 && cyc < 400) begin
            exp_sn = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (((cyc >> (2 * i)) & 3) >= x[i]) exp_sn = 1'b0;
            end
            chk({tag, " sn"}, longint'(sn4), longint'(exp_sn));
            chk({tag, " z_held"}, longint'(z4), exp_z4);
            ones += int'(sn4);
            step();
            cyc++;
        end
        exp_z4 = prod;
        chk({tag, " run_cycles"}, longint'(cyc), (prod == 0) ? 0 : 256);
        chk({tag, " done"}, longint'(done4), 1);
        chk({tag, " z"}, longint'(z4), prod);
        if (prod != 0) chk({tag, " ones"}, longint'(ones), prod);
        step();
        chk({tag, " done_pulse"}, longint'(done4), 0);
        chk({tag, " z_kept"}, longint'(z4), exp_z4);
    endtask

    initial begin
        rst = 1'b1;
        start2 = 1'b0;
        start4 = 1'b0;
        din2 = 6'd9;
        din4 = 8'd0;
        step();
        step();
        chk("rst busy2", longint'(busy2), 0);
        chk("rst done2", longint'(done2), 0);
        chk("rst z2", longint'(z2), 0);
        chk("rst sn2", longint'(sn2), 0);
        chk("rst busy4", longint'(busy4), 0);
        chk("rst z4", longint'(z4), 0);
        rst = 1'b0;
        step();
        chk("idle after rst", longint'(busy2), 0);

        run2(5, 6, -1, -1, "m5x6");
        idle2("m5x6");

        run2(7, 7, -1, -1, "m7x7");
        run2(1, 1, -1, -1, "m1x1_on_done");
        idle2("m1x1");

        run2(0, 7, -1, -1, "zero_op");
        idle2("zero_op");

        run2(5, 6, -1, 20, "abort");
        idle2("abort");
        run2(2, 3, -1, -1, "m2x3");
        idle2("m2x3");

        run2(4, 4, 10, -1, "stray_start");
        idle2("stray_start");

        for (int k = 0; k < 6; k++) begin
            run2(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), -1, -1, "rand2");
            idle2("rand2");
        end

        run4(3, 3, 3, 3, "m3333");
        run4(1, 2, 3, 2, "m1232");
        for (int k = 0; k < 3; k++) begin
            run4(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                 int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), "rand4");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
